iter_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 14 +
 rtl/iter_counter.sv | 110 +++++++++++
 tb/tb_iter_counter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and encodings for the iteration counter
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } iter_state_t;

  // Free-run overflow policy encodings for the MODE_WRAP parameter.
  localparam int MODE_WRAP_EN = 1;
  localparam int MODE_SAT     = 0;

endpackage

// File: rtl/iter_counter.sv
// rtl/iter_counter.sv - free-run / bounded-run iteration counter for the Booth multiplier
module iter_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int MODE_WRAP = MODE_WRAP_EN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic             up_dn,
  input  logic             en_pp,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  iter_state_t      state;
  logic [WIDTH-1:0] limit_q;
  logic             dir_q;

  logic [WIDTH-1:0] free_next;
  logic [WIDTH-1:0] run_next;
  logic             run_hit;

  // Next-count arithmetic: free-run step with overflow policy, and bounded-run step with terminal detect.
  always_comb begin
    free_next = out + ONE;
    run_next  = out;
    run_hit   = 1'b0;
    if (out == ALL_ONES) begin
      free_next = (MODE_WRAP == MODE_WRAP_EN) ? '0 : out;
    end
    if (dir_q) begin
      run_next = out + ONE;
      run_hit  = (run_next == limit_q);
    end else begin
      run_next = out - ONE;
      run_hit  = (run_next == '0);
    end
  end

  // Control FSM and registered outputs; tc and done default low so each is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      out     <= '0;
      tc      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      limit_q <= '0;
      dir_q   <= 1'b1;
    end else if (clear) begin
      state <= IDLE;
      out   <= '0;
      tc    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      tc   <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            limit_q <= limit;
            dir_q   <= up_dn;
            if (limit == '0) begin
              // A zero-length run completes at once without ever raising busy.
              out   <= '0;
              tc    <= 1'b1;
              state <= DONE;
            end else begin
              out   <= up_dn ? '0 : limit;
              busy  <= 1'b1;
              state <= RUN;
            end
          end else if (en_pp) begin
            out <= free_next;
          end
        end
        RUN: begin
          // The terminal value is reachable only by single steps, so no overflow handling is needed here.
          if (en_pp) begin
            out <= run_next;
            if (run_hit) begin
              tc    <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_counter.sv
// tb/tb_iter_counter.sv - scoreboard bench for iter_counter
module tb_iter_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic [3:0] limit = 4'd0;
  logic       up_dn = 1'b1;
  logic       en_pp = 1'b0;

  logic [3:0] out_w, out_s;
  logic       tc_w, busy_w, done_w;
  logic       tc_s, busy_s, done_s;

  int checks = 0;
  int failures = 0;
  int step_no = 0;

  typedef struct {
    logic [3:0] out;
    logic       tc;
    logic       busy;
    logic       done;
    logic [3:0] out_sat;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  iter_counter #(.WIDTH(4), .MODE_WRAP(1)) dut_wrap (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .limit(limit),
    .up_dn(up_dn), .en_pp(en_pp), .out(out_w), .tc(tc_w), .busy(busy_w), .done(done_w)
  );

  iter_counter #(.WIDTH(4), .MODE_WRAP(0)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .limit(limit),
    .up_dn(up_dn), .en_pp(en_pp), .out(out_s), .tc(tc_s), .busy(busy_s), .done(done_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, then compare after the edge.
  task automatic step(input logic st, input logic en, input logic clr, input logic [3:0] lim,
                      input logic ud, input logic [3:0] e_out, input logic e_tc, input logic e_busy,
                      input logic e_done, input logic [3:0] e_sat);
    exp_t e;
    @(negedge clk);
    start = st;
    en_pp = en;
    clear = clr;
    limit = lim;
    up_dn = ud;
    e.out = e_out;
    e.tc = e_tc;
    e.busy = e_busy;
    e.done = e_done;
    e.out_sat = e_sat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    if (exp_q.size() == 0) begin
      check($sformatf("scoreboard_empty@%0d", step_no), 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("out@%0d", step_no), {28'd0, out_w}, {28'd0, e.out});
      check($sformatf("tc@%0d", step_no), {31'd0, tc_w}, {31'd0, e.tc});
      check($sformatf("busy@%0d", step_no), {31'd0, busy_w}, {31'd0, e.busy});
      check($sformatf("done@%0d", step_no), {31'd0, done_w}, {31'd0, e.done});
      check($sformatf("out_sat@%0d", step_no), {28'd0, out_s}, {28'd0, e.out_sat});
    end
  endtask

  task automatic idle(input logic [3:0] e_out, input logic e_tc, input logic e_busy, input logic e_done);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, e_out, e_tc, e_busy, e_done, e_out);
  endtask

  task automatic run_step(input logic en, input logic [3:0] e_out, input logic e_tc);
    step(1'b0, en, 1'b0, 4'd0, 1'b1, e_out, e_tc, 1'b1, 1'b0, e_out);
  endtask

  initial begin
    // Reset state, before any clock edge.
    #2;
    check("reset_out", {28'd0, out_w}, 32'd0);
    check("reset_tc", {31'd0, tc_w}, 32'd0);
    check("reset_busy", {31'd0, busy_w}, 32'd0);
    check("reset_done", {31'd0, done_w}, 32'd0);
    check("reset_out_sat", {28'd0, out_s}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Free-run: wrap instance goes 1..15,0,1; saturating instance holds at 15.
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'((i + 1) % 16), 1'b0, 1'b0, 1'b0,
           (i + 1 > 15) ? 4'd15 : 4'(i + 1));
    end
    step(1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Up run to 5.
    step(1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 1; i <= 5; i++) run_step(1'b1, 4'(i), (i == 5));
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 4'd5);
    idle(4'd5, 1'b0, 1'b0, 1'b0);

    // Down run from 3 with an idle gap.
    step(1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 4'd3);
    run_step(1'b1, 4'd2, 1'b0);
    run_step(1'b0, 4'd2, 1'b0);
    run_step(1'b1, 4'd1, 1'b0);
    run_step(1'b1, 4'd0, 1'b1);
    idle(4'd0, 1'b0, 1'b0, 1'b1);
    idle(4'd0, 1'b0, 1'b0, 1'b0);

    // Priority: start beats en_pp; start/limit/up_dn ignored in RUN; clear aborts without done.
    step(1'b1, 1'b1, 1'b0, 4'd4, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 4'd1);
    step(1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 4'd2);
    step(1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    idle(4'd0, 1'b0, 1'b0, 1'b0);
    idle(4'd0, 1'b0, 1'b0, 1'b0);

    // Zero limit: tc then done, no busy; then a back-to-back down run of 2.
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    idle(4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 4'd2);
    run_step(1'b1, 4'd1, 1'b0);
    run_step(1'b1, 4'd0, 1'b1);
    idle(4'd0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-run at out=3 of limit 7.
    step(1'b1, 1'b1, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 1; i <= 3; i++) run_step(1'b1, 4'(i), 1'b0);
    @(negedge clk);
    en_pp = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("async_out", {28'd0, out_w}, 32'd0);
    check("async_busy", {31'd0, busy_w}, 32'd0);
    check("async_tc", {31'd0, tc_w}, 32'd0);
    check("async_done", {31'd0, done_w}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    run_step(1'b1, 4'd1, 1'b0);
    run_step(1'b1, 4'd2, 1'b1);
    idle(4'd2, 1'b0, 1'b0, 1'b1);
    idle(4'd2, 1'b0, 1'b0, 1'b0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
